// File: rtl/split_output_bcd_if.sv
// Bus between the time/date counters and the BCD splitter, and from the
// splitter on to the display multiplexer.
// Optional macro: SPLIT_SEG7_EN adds active-low seven-segment digit outputs.
//
// Handshake: in_valid qualifies total for one rising clk edge; there is no
// ready, so every edge with in_valid high is an accepted transfer. out_valid
// pulses high for exactly one cycle, one cycle after each accepted transfer,
// and left/right/overflow (and seg_* when present) are valid while it is high
// and hold their values afterwards.
interface split_output_bcd_if;
    logic [7:0] total;
    logic       in_valid;
    logic [3:0] left;
    logic [3:0] right;
    logic       out_valid;
    logic       overflow;
`ifdef SPLIT_SEG7_EN
    logic [6:0] seg_left;
    logic [6:0] seg_right;
`endif

    // Producer side: the counters driving a value in, reading the digits back.
    modport master (
        output total,
        output in_valid,
        input  left,
        input  right,
        input  out_valid,
        input  overflow
`ifdef SPLIT_SEG7_EN
        ,
        input  seg_left,
        input  seg_right
`endif
    );

    // Splitter side.
    modport slave (
        input  total,
        input  in_valid,
        output left,
        output right,
        output out_valid,
        output overflow
`ifdef SPLIT_SEG7_EN
        ,
        output seg_left,
        output seg_right
`endif
    );
endinterface

// File: rtl/split_output_bcd.sv
// Splits an 8-bit binary count (seconds, minutes, hours, day, month) into
// two BCD digits with one registered cycle of latency. Values above MAX_VAL
// saturate to the digits of MAX_VAL and raise overflow.
// Optional macro: SPLIT_SEG7_EN adds registered active-low seven-segment
// codes ({g,f,e,d,c,b,a}) for both digits, blank after reset.
module split_output_bcd #(
    parameter int MAX_VAL = 99
) (
    input logic                clk,
    input logic                rst_n,
    split_output_bcd_if.slave  bus
);

    localparam logic [7:0] MAX_VAL_B = 8'(MAX_VAL);

    logic        over;
    logic [7:0]  clamped;
    logic [15:0] prod;
    logic [3:0]  tens;
    logic [3:0]  units;

`ifdef SPLIT_SEG7_EN
    // Active-low cathodes {g,f,e,d,c,b,a}; anything outside 0-9 blanks.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction
`endif

    // Saturate, then divide by 10 as x*205 >> 11 (exact for every 8-bit x),
    // with the multiply written as shifts and adds. The remainder is formed
    // in 4 bits since it is always below 10, so the wrap is harmless.
    always_comb begin
        over    = (bus.total > MAX_VAL_B);
        clamped = over ? MAX_VAL_B : bus.total;
        prod    = ({8'd0, clamped} << 7) + ({8'd0, clamped} << 6)
                + ({8'd0, clamped} << 3) + ({8'd0, clamped} << 2)
                + {8'd0, clamped};
        tens    = 4'(prod >> 11);
        units   = clamped[3:0] - {tens[2:0], 1'b0} - {tens[0], 3'b000};
    end

    // Output register: reset wins, accepted inputs load, idle cycles hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.left      <= 4'd0;
            bus.right     <= 4'd0;
            bus.out_valid <= 1'b0;
            bus.overflow  <= 1'b0;
`ifdef SPLIT_SEG7_EN
            bus.seg_left  <= 7'b1111111;
            bus.seg_right <= 7'b1111111;
`endif
        end else if (bus.in_valid) begin
            bus.left      <= tens;
            bus.right     <= units;
            bus.out_valid <= 1'b1;
            bus.overflow  <= over;
`ifdef SPLIT_SEG7_EN
            bus.seg_left  <= seg7(tens);
            bus.seg_right <= seg7(units);
`endif
        end else begin
            bus.out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_split_output_bcd.sv
// Bench for split_output_bcd: directed steps from the test plan, a full
// 0-255 sweep and random traffic, checked against an arithmetic model.
module tb_split_output_bcd;

    logic clk;
    logic rst_n;

    split_output_bcd_if bus ();

    split_output_bcd #(.MAX_VAL(99)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int         checks_total;
    int         checks_passed;
    logic [8:0] exp_q[$];        // {overflow, tens, units}
    logic [3:0] m_left;
    logic [3:0] m_right;
    logic       m_ovf;
    logic [6:0] seg_tbl[10];

    // Reference: saturate to 99, then ordinary integer / and %.
    function automatic logic [8:0] model(input logic [7:0] t);
        int c;
        c = (int'(t) > 99) ? 99 : int'(t);
        return {(int'(t) > 99), 4'(c / 10), 4'(c % 10)};
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks_total++;
        assert (obs === exp) checks_passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // ---------------- driver ----------------
    // Apply one cycle of inputs at the falling edge, sample 1 time unit after
    // the following rising edge and compare with the model.
    task automatic drive(input logic r, input logic v, input logic [7:0] t);
        logic [8:0] e;
        @(negedge clk);
        rst_n        = r;
        bus.in_valid = v;
        bus.total    = t;
        if (r && v) exp_q.push_back(model(t));
        @(posedge clk);
        #1;
        if (!r) begin
            exp_q.delete();
            m_left  = 4'd0;
            m_right = 4'd0;
            m_ovf   = 1'b0;
            check("rst_out_valid", 8'(bus.out_valid), 8'd0);
        end else if (v) begin
            e       = exp_q.pop_front();
            m_ovf   = e[8];
            m_left  = e[7:4];
            m_right = e[3:0];
            check($sformatf("acc_out_valid t=%0d", t), 8'(bus.out_valid), 8'd1);
        end else begin
            check("idle_out_valid", 8'(bus.out_valid), 8'd0);
        end
        check($sformatf("left t=%0d v=%0b r=%0b", t, v, r), 8'(bus.left), 8'(m_left));
        check($sformatf("right t=%0d v=%0b r=%0b", t, v, r), 8'(bus.right), 8'(m_right));
        check($sformatf("overflow t=%0d v=%0b r=%0b", t, v, r), 8'(bus.overflow), 8'(m_ovf));
`ifdef SPLIT_SEG7_EN
        if (!r) begin
            check("rst_seg_left", 8'(bus.seg_left), 8'h7F);
            check("rst_seg_right", 8'(bus.seg_right), 8'h7F);
        end else begin
            check($sformatf("seg_left t=%0d", t), 8'(bus.seg_left), 8'(seg_tbl[m_left]));
            check($sformatf("seg_right t=%0d", t), 8'(bus.seg_right), 8'(seg_tbl[m_right]));
        end
`endif
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] plan_a[6];
        logic [7:0] plan_b[6];

        checks_total  = 0;
        checks_passed = 0;
        m_left        = 4'd0;
        m_right       = 4'd0;
        m_ovf         = 1'b0;
        seg_tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.total    = 8'd0;

        // Reset held for two edges while a value is presented.
        drive(1'b0, 1'b1, 8'd31);
        drive(1'b0, 1'b1, 8'd31);

        // Back-to-back accepts.
        plan_a = '{8'd31, 8'd12, 8'd9, 8'd15, 8'd27, 8'd31};
        foreach (plan_a[i]) drive(1'b1, 1'b1, plan_a[i]);

        // Boundaries, saturation and recovery.
        plan_b = '{8'd0, 8'd10, 8'd99, 8'd100, 8'd255, 8'd42};
        foreach (plan_b[i]) drive(1'b1, 1'b1, plan_b[i]);

        // Hold after an accept while total wanders.
        drive(1'b1, 1'b1, 8'd57);
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 8'($urandom_range(0, 255)));
        check("hold_left_57", 8'(bus.left), 8'd5);
        check("hold_right_57", 8'(bus.right), 8'd7);

        // Segment sample, then reset mid-stream with an input presented.
        drive(1'b1, 1'b1, 8'd48);
`ifdef SPLIT_SEG7_EN
        check("seg48_left", 8'(bus.seg_left), 8'(7'b0011001));
        check("seg48_right", 8'(bus.seg_right), 8'(7'b0000000));
`endif
        drive(1'b0, 1'b1, 8'd77);
        drive(1'b1, 1'b0, 8'd77);

        // Every input value back-to-back, plus the digit identity for 0-99.
        for (int t = 0; t < 256; t++) begin
            drive(1'b1, 1'b1, 8'(t));
            if (t <= 99) check($sformatf("recombine t=%0d", t),
                               8'(10 * int'(bus.left) + int'(bus.right)), 8'(t));
        end

        // Random traffic with occasional idles and resets.
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 31) != 0), ($urandom_range(0, 3) != 0),
                  8'($urandom_range(0, 255)));
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
